video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 288: visible pixels per line.
REQ-002 Parameters H_FP 23, H_SYNC 31, H_BP 42: horizontal front porch, sync and back porch widths in pixels; H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
REQ-003 Parameters V_ACTIVE 224, V_FP 3, V_SYNC 7, V_BP 29: vertical equivalents in lines; V_TOTAL is their sum.
REQ-004 Parameter CW, 12: RGB bus width. Parameter CNT_W, 9: hpos/vpos width.
REQ-005 Parameters HS_POL and VS_POL, default 0: sync active level (0 = active-low).
REQ-006 clk_sys  in  1  single clock for all logic.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 ce_pix  in  1  pixel enable; all state advances only on clk_sys edges with ce_pix=1.
REQ-009 rgb_in  in  CW  pixel colour for the current hpos/vpos.
REQ-010 h_adj, v_adj  in  4 each  signed sync position shift in pixels/lines.
REQ-011 hpos, vpos  out  CNT_W each  current counter values.
REQ-012 rgb_out  out  CW  blanked, registered colour.
REQ-013 hblank, vblank, de, hsync, vsync  out  1 each  timing flags.
REQ-014 frame_start  out  1  one-clk_sys pulse when the counters wrap to (0,0).

Function
REQ-015 hpos SHALL count 0..H_TOTAL-1 on ce_pix and wrap to 0; vpos SHALL increment on each hpos wrap and wrap to 0 after V_TOTAL-1.
REQ-016 hblank SHALL be 1 iff hpos >= H_ACTIVE; vblank SHALL be 1 iff vpos >= V_ACTIVE; de SHALL equal ~hblank & ~vblank. All three are decoded from the current counter registers, with no lag.
REQ-017 Sync start position HS0 = H_ACTIVE + H_FP + h_adj_l, clamped to [H_ACTIVE, H_TOTAL - H_SYNC]. hsync SHALL be at HS_POL iff HS0 <= hpos < HS0 + H_SYNC, and at ~HS_POL otherwise.
REQ-018 vsync SHALL be derived as in REQ-017 using V parameters, vpos and v_adj_l. Transitions occur at hpos = 0.
REQ-019 h_adj_l and v_adj_l SHALL be sampled from h_adj and v_adj only on the ce_pix cycle that wraps the counters to (0,0), so a shift never splits a frame.
REQ-020 rgb_out SHALL be registered on ce_pix as 0 when (hblank | vblank), else rgb_in. This gives a latency of one ce_pix relative to hpos.
REQ-021 frame_start SHALL be high for exactly one clk_sys cycle: the cycle after the ce_pix edge that loads (0,0).
REQ-022 When ce_pix=0, all outputs SHALL hold their values, and frame_start SHALL be 0.
REQ-023 Elaboration SHALL fail if H_TOTAL > 2**CNT_W, if V_TOTAL > 2**CNT_W, or if any SYNC parameter is 0.

Reset
REQ-024 On reset assertion, the following SHALL be forced asynchronously: hpos=0, vpos=0, h_adj_l=0, v_adj_l=0, rgb_out=0, frame_start=0.
REQ-025 While reset is held, outputs SHALL be: hblank=0, vblank=0, de=1, hsync=~HS_POL, vsync=~VS_POL.
REQ-026 On reset release, counting SHALL resume at the first ce_pix. Reset asserted mid-frame SHALL abort the frame with no frame_start pulse.

Configuration
REQ-027 Macro VTG_SCREEN_SHIFT_EN: when defined, h_adj and v_adj are sampled per REQ-019.
REQ-028 When VTG_SCREEN_SHIFT_EN is not defined, h_adj_l and v_adj_l SHALL be constant 0. The h_adj and v_adj ports remain present but are ignored, and no sampling logic is built.

Verification
REQ-029 Defaults, ce_pix every 4th clk: hblank rises at hpos=288. hsync is low for hpos 311..341. Line length is 384 ce_pix. Frame length is 384*263 ce_pix. frame_start pulses once per frame.
REQ-030 h_adj=+7 set mid-frame: the current frame still has hsync at 311. From the next frame onward, hsync starts at 318.
REQ-031 v_adj=-8 with V_FP=3: vsync is clamped to start at vpos=224 and lasts 7 lines.
REQ-032 rgb_in constant 12'hFFF: rgb_out is 12'hFFF one ce_pix after hpos=0. rgb_out is 0 one ce_pix after hpos=288 and throughout vpos 224..262.
REQ-033 Reset asserted at hpos=100, vpos=50: outputs immediately show hpos=0, vpos=0, rgb_out=0 and inactive syncs; no frame_start occurs.
REQ-034 Build without VTG_SCREEN_SHIFT_EN and h_adj=+5: hsync stays at 311..341 in every frame.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, DE, adjustable syncs and blanked RGB.
// Optional macro VTG_SCREEN_SHIFT_EN enables per-frame sampling of the h_adj/v_adj sync shifts.
module video_timing_gen #(
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 23,
  parameter int H_SYNC   = 31,
  parameter int H_BP     = 42,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 29,
  parameter int CW       = 12,
  parameter int CNT_W    = 9,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce_pix,
  input  logic [CW-1:0]           rgb_in,
  input  logic signed [3:0]       h_adj,
  input  logic signed [3:0]       v_adj,
  output logic [CNT_W-1:0]        hpos,
  output logic [CNT_W-1:0]        vpos,
  output logic [CW-1:0]           rgb_out,
  output logic                    hblank,
  output logic                    vblank,
  output logic                    de,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = CNT_W + 2;

  if (H_TOTAL > (1 << CNT_W)) begin : g_err_htotal
    $error("H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_err_vtotal
    $error("V_TOTAL does not fit in CNT_W bits");
  end
  if (H_SYNC == 0 || V_SYNC == 0) begin : g_err_sync
    $error("sync width must be non-zero");
  end

  logic [CNT_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [CW-1:0]    rgb_q, rgb_d;
  logic             fs_q, fs_d;
  logic             h_last, v_last, frame_wrap;
  logic signed [3:0] h_adj_l, v_adj_l;

  assign h_last     = (hpos_q == CNT_W'(H_TOTAL - 1));
  assign v_last     = (vpos_q == CNT_W'(V_TOTAL - 1));
  assign frame_wrap = ce_pix & h_last & v_last;

  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    rgb_d  = rgb_q;
    fs_d   = frame_wrap;
    if (ce_pix) begin
      hpos_d = h_last ? '0 : hpos_q + 1'b1;
      if (h_last) vpos_d = v_last ? '0 : vpos_q + 1'b1;
      rgb_d  = (hblank | vblank) ? '0 : rgb_in;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hpos_q <= '0;
      vpos_q <= '0;
      rgb_q  <= '0;
      fs_q   <= 1'b0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      rgb_q  <= rgb_d;
      fs_q   <= fs_d;
    end
  end

`ifdef VTG_SCREEN_SHIFT_EN
  logic signed [3:0] h_adj_q, v_adj_q;

  // Shifts only take effect at the frame boundary so one frame never mixes two positions.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      h_adj_q <= '0;
      v_adj_q <= '0;
    end else if (frame_wrap) begin
      h_adj_q <= h_adj;
      v_adj_q <= v_adj;
    end
  end
  assign h_adj_l = h_adj_q;
  assign v_adj_l = v_adj_q;
`else
  logic unused_adj;
  assign unused_adj = ^{h_adj, v_adj};
  assign h_adj_l    = '0;
  assign v_adj_l    = '0;
`endif

  // Sync window test: nominal start shifted by adj, clamped so the pulse stays inside blanking.
  function automatic logic sync_hit(input logic [CNT_W-1:0] pos, input logic signed [3:0] adj,
                                    input int nom, input int lo, input int hi, input int width);
    logic signed [SW-1:0] start;
    logic [SW-1:0]        p;
    start = SW'(nom) + SW'(adj);
    if (start < SW'(lo))      start = SW'(lo);
    else if (start > SW'(hi)) start = SW'(hi);
    p = SW'(pos);
    return (p >= $unsigned(start)) && (p < $unsigned(start) + $unsigned(SW'(width)));
  endfunction

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign rgb_out     = rgb_q;
  assign frame_start = fs_q;
  assign hblank      = (hpos_q >= CNT_W'(H_ACTIVE));
  assign vblank      = (vpos_q >= CNT_W'(V_ACTIVE));
  assign de          = ~hblank & ~vblank;
  assign hsync = sync_hit(hpos_q, h_adj_l, H_ACTIVE + H_FP, H_ACTIVE, H_TOTAL - H_SYNC, H_SYNC)
                 ? HS_POL : ~HS_POL;
  assign vsync = sync_hit(vpos_q, v_adj_l, V_ACTIVE + V_FP, V_ACTIVE, V_TOTAL - V_SYNC, V_SYNC)
                 ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default horizontal timing, short vertical timing
// (V_ACTIVE 6, V_FP 3, V_SYNC 7, V_BP 2 -> 18 lines) so several whole frames fit in a short run.
module tb_video_timing_gen;

  localparam int H_ACT = 288;
  localparam int H_TOT = 384;
  localparam int V_ACT = 6;
  localparam int V_TOT = 18;
  localparam int FRAME = H_TOT * V_TOT;
`ifdef VTG_SCREEN_SHIFT_EN
  localparam bit SHIFT = 1'b1;
`else
  localparam bit SHIFT = 1'b0;
`endif

  logic              clk_sys, reset, ce_pix;
  logic [11:0]       rgb_in;
  logic signed [3:0] h_adj, v_adj;
  logic [8:0]        hpos, vpos;
  logic [11:0]       rgb_out;
  logic              hblank, vblank, de, hsync, vsync, frame_start;

  video_timing_gen #(
    .V_ACTIVE(6), .V_FP(3), .V_SYNC(7), .V_BP(2)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .rgb_in(rgb_in),
    .h_adj(h_adj), .v_adj(v_adj), .hpos(hpos), .vpos(vpos), .rgb_out(rgb_out),
    .hblank(hblank), .vblank(vblank), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  int checks = 0;
  int errors = 0;
  int fs_count = 0;
  int m_h, m_v, exp_hs0, exp_vs0, next_hs0, next_vs0;
  logic [11:0] exp_rgb;
  logic exp_fs;
  bit pattern;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at h=%0d v=%0d: observed %0h expected %0h", tag, m_h, m_v, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hpos", 32'(hpos), 32'(m_h));
    chk("vpos", 32'(vpos), 32'(m_v));
    chk("hblank", 32'(hblank), 32'(m_h >= H_ACT));
    chk("vblank", 32'(vblank), 32'(m_v >= V_ACT));
    chk("de", 32'(de), 32'(m_h < H_ACT && m_v < V_ACT));
    chk("hsync", 32'(hsync), 32'(!(m_h >= exp_hs0 && m_h < exp_hs0 + 31)));
    chk("vsync", 32'(vsync), 32'(!(m_v >= exp_vs0 && m_v < exp_vs0 + 7)));
    chk("rgb_out", 32'(rgb_out), 32'(exp_rgb));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    if (frame_start === 1'b1) fs_count++;
  endtask

  // One ce_pix pulse followed by gap idle clocks; model advanced alongside.
  task automatic pix(input int gap);
    rgb_in  = pattern ? 12'(m_h * 5 + m_v * 3) : 12'hFFF;
    exp_rgb = (m_h >= H_ACT || m_v >= V_ACT) ? 12'h000 : rgb_in;
    exp_fs  = 1'b0;
    if (m_h == H_TOT - 1) begin
      m_h = 0;
      if (m_v == V_TOT - 1) begin
        m_v    = 0;
        exp_fs = 1'b1;
        if (SHIFT) begin
          exp_hs0 = next_hs0;
          exp_vs0 = next_vs0;
        end
      end else m_v++;
    end else m_h++;
    ce_pix = 1'b1;
    @(posedge clk_sys); #1;
    ce_pix = 1'b0;
    check_all();
    exp_fs = 1'b0;
    repeat (gap) begin
      @(posedge clk_sys); #1;
      check_all();
    end
  endtask

  task automatic run(input int n, input int gap);
    for (int i = 0; i < n; i++) pix(gap);
  endtask

  task automatic set_adj(input int h, input int v, input int hs0, input int vs0);
    h_adj    = 4'(h);
    v_adj    = 4'(v);
    next_hs0 = hs0;
    next_vs0 = vs0;
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0;
    exp_rgb = 12'h000; exp_fs = 1'b0;
    exp_hs0 = 311; exp_vs0 = 9;
  endtask

  initial begin
    reset = 1'b1; ce_pix = 1'b0; rgb_in = 12'hFFF; pattern = 1'b0;
    set_adj(0, 0, 311, 9);
    model_reset();
    #1;
    check_all();
    repeat (2) begin
      @(posedge clk_sys); #1;
      check_all();
    end
    reset = 1'b0;

    // Frame 0: first two lines at one ce_pix per 4 clocks, rest at full rate.
    run(2 * H_TOT, 3);
    run(3 * H_TOT, 0);
    set_adj(7, -8, 318, 6);
    run(FRAME - 5 * H_TOT, 0);

    // Frame 1: +7 / -8 applied (vsync clamped to line 6); new shift requested mid-frame.
    run(2000, 0);
    pattern = 1'b1;
    set_adj(-8, 7, 303, 11);
    run(FRAME - 2000, 0);

    // Frame 2: vsync clamped high to line 11; aborted by reset at line 5, pixel 100.
    run(5 * H_TOT + 100, 0);
    chk("pre_reset_hpos", 32'(hpos), 32'd100);
    reset = 1'b1;
    model_reset();
    #2;
    check_all();
    repeat (3) begin
      @(posedge clk_sys); #1;
      check_all();
    end
    reset = 1'b0;

    // Restart from (0,0) with unshifted syncs, then into the following frame.
    run(FRAME, 0);
    run(12 * H_TOT, 0);

    chk("frame_count", 32'(fs_count), 32'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
